// File: rtl/rv_writeback_regfile.sv
// ---------------------------------------------------------------------------
// rv_writeback_regfile
//
// Writeback end of the execute path. It accepts ALU results (rd index plus
// value) over a ready/valid handshake and commits them into a NREGS x XLEN
// architectural register file. It also provides two registered read ports
// that feed the ALU operand inputs.
//
// Write path:
//   - An accepted write sits in a one-entry pending stage (stage p1).
//   - The pending entry commits to the array on the following edge.
//   - Both read ports forward from the incoming write and from the pending
//     entry, so a dependent instruction issued the very next cycle sees the
//     new value.
//
// Reset and clear:
//   - After reset, a clear sequencer writes zero to x1..x(NREGS-1), one
//     register per edge.
//   - The writeback handshake opens only once that sequence has finished.
//   - With CLEAR_ON_RESET=0 the block goes straight to RUN.
//
// Ports:
//   clk          single clock, all state updates on the rising edge
//   rst          synchronous, active-high reset
//   wb_valid     ALU result present this cycle
//   wb_ready     block can accept a writeback (registered, high in RUN)
//   wb_rd_addr   destination register index
//   wb_rd_value  result value to commit
//   rs1_en       read request, port 1
//   rs1_addr     read index, port 1
//   rs1_value    registered read data, port 1 (holds while rs1_en=0)
//   rs2_en       read request, port 2
//   rs2_addr     read index, port 2
//   rs2_value    registered read data, port 2 (holds while rs2_en=0)
//   init_done    high once the clear sequence has finished
// ---------------------------------------------------------------------------
module rv_writeback_regfile #(
  parameter int XLEN           = 32,
  parameter int NREGS          = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [$clog2(NREGS)-1:0] wb_rd_addr,
  input  logic [XLEN-1:0]          wb_rd_value,
  input  logic                     rs1_en,
  input  logic [$clog2(NREGS)-1:0] rs1_addr,
  output logic [XLEN-1:0]          rs1_value,
  input  logic                     rs2_en,
  input  logic [$clog2(NREGS)-1:0] rs2_addr,
  output logic [XLEN-1:0]          rs2_value,
  output logic                     init_done
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;

  // Architectural storage. x0 is never written; reads of x0 short-circuit to 0.
  logic [XLEN-1:0] regs [NREGS];

  // Control state
  state_t          state_q;
  state_t          state_d;
  logic [AW-1:0]   clr_idx_q;
  logic [AW-1:0]   clr_idx_d;
  logic            clr_we;

  // Pending-write stage (p1): control valid plus data
  logic            vld_p1;
  logic [AW-1:0]   pending_addr_p1;
  logic [XLEN-1:0] pending_value_p1;

  // Handshake
  logic            accept;

  // Read-port select results
  logic [XLEN-1:0] rd1_sel;
  logic [XLEN-1:0] rd2_sel;

  assign accept = wb_valid & wb_ready;

  // -------------------------------------------------------------------------
  // Read source priority:
  //   1. x0 reads as zero.
  //   2. Everything reads as zero while the clear is running.
  //      The array is only partially cleared at that point.
  //   3. A write accepted on this same edge.
  //   4. The pending entry.
  //   5. The array.
  // -------------------------------------------------------------------------
  function automatic logic [XLEN-1:0] read_select(
    input logic [AW-1:0]   addr,
    input logic            in_init,
    input logic            wb_acc,
    input logic [AW-1:0]   wb_addr,
    input logic [XLEN-1:0] wb_value,
    input logic            pend_vld,
    input logic [AW-1:0]   pend_addr,
    input logic [XLEN-1:0] pend_value,
    input logic [XLEN-1:0] arr_value
  );
    logic [XLEN-1:0] res;
    if (addr == '0) begin
      res = '0;
    end else if (in_init) begin
      res = '0;
    end else if (wb_acc && (wb_addr == addr)) begin
      res = wb_value;
    end else if (pend_vld && (pend_addr == addr)) begin
      res = pend_value;
    end else begin
      res = arr_value;
    end
    return res;
  endfunction

  always_comb begin
    rd1_sel = read_select(rs1_addr, (state_q == ST_INIT), accept, wb_rd_addr,
                          wb_rd_value, vld_p1, pending_addr_p1,
                          pending_value_p1, regs[rs1_addr]);
    rd2_sel = read_select(rs2_addr, (state_q == ST_INIT), accept, wb_rd_addr,
                          wb_rd_value, vld_p1, pending_addr_p1,
                          pending_value_p1, regs[rs2_addr]);
  end

  // -------------------------------------------------------------------------
  // Next-state logic for the clear sequencer
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    clr_we    = 1'b0;
    case (state_q)
      ST_INIT: begin
        clr_we    = 1'b1;
        clr_idx_d = clr_idx_q + AW'(1);
        if (clr_idx_q == LAST_IDX) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Stage p0 -> p1: control registers.
  // wb_ready and init_done follow the next state.
  // They therefore rise on the same edge that enters RUN.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RESET_STATE;
      clr_idx_q <= AW'(1);
      vld_p1    <= 1'b0;
      wb_ready  <= 1'b0;
      init_done <= 1'b0;
      rs1_value <= '0;
      rs2_value <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      wb_ready  <= (state_d == ST_RUN);
      init_done <= (state_d == ST_RUN);
      // A write to x0 leaves the stage empty once any older entry commits.
      vld_p1    <= accept && (wb_rd_addr != '0);
      if (rs1_en) begin
        rs1_value <= rd1_sel;
      end
      if (rs2_en) begin
        rs2_value <= rd2_sel;
      end
    end
  end

  // Pending data captures on every accept.
  // vld_p1 alone decides whether the captured entry is live.
  always_ff @(posedge clk) begin
    if (accept) begin
      pending_addr_p1  <= wb_rd_addr;
      pending_value_p1 <= wb_rd_value;
    end
  end

  // -------------------------------------------------------------------------
  // Stage p1 -> array: commit the pending entry, or clear one register.
  // Nothing is written on a reset edge, so a pending entry is dropped.
  // vld_p1 is only ever set in RUN, so the two write sources never collide.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        regs[clr_idx_q] <= '0;
      end else if (vld_p1) begin
        regs[pending_addr_p1] <= pending_value_p1;
      end
    end
  end

endmodule

// File: tb/tb_rv_writeback_regfile.sv
// ---------------------------------------------------------------------------
// tb_rv_writeback_regfile
//
// Directed scoreboard bench for rv_writeback_regfile.
//
// Stimulus side:
//   - Inputs are driven at the falling edge.
//   - For every read issued, the hand-computed expected value is pushed into
//     a per-port queue.
//
// Monitor side:
//   - The monitor samples rsN_en at the rising edge.
//   - Shortly after that edge it pops the queue and compares against rsN_value.
// ---------------------------------------------------------------------------
module tb_rv_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_value;
  logic        rs1_en;
  logic [4:0]  rs1_addr;
  logic [31:0] rs1_value;
  logic        rs2_en;
  logic [4:0]  rs2_addr;
  logic [31:0] rs2_value;
  logic        init_done;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp1_q[$];
  logic [31:0] exp2_q[$];
  string       name1_q[$];
  string       name2_q[$];

  rv_writeback_regfile #(
    .XLEN(32),
    .NREGS(32),
    .CLEAR_ON_RESET(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_rd_addr (wb_rd_addr),
    .wb_rd_value(wb_rd_value),
    .rs1_en     (rs1_en),
    .rs1_addr   (rs1_addr),
    .rs1_value  (rs1_value),
    .rs2_en     (rs2_en),
    .rs2_addr   (rs2_addr),
    .rs2_value  (rs2_value),
    .init_done  (init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One cycle of stimulus.
  // The expected read results are queued before the sampling edge.
  task automatic cyc(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                     input logic e1, input logic [4:0] a1, input logic [31:0] x1,
                     input logic e2, input logic [4:0] a2, input logic [31:0] x2,
                     input string name);
    wb_valid = wv; wb_rd_addr = wa; wb_rd_value = wd;
    rs1_en = e1; rs1_addr = a1;
    rs2_en = e2; rs2_addr = a2;
    if (e1) begin exp1_q.push_back(x1); name1_q.push_back({name, "_rs1"}); end
    if (e2) begin exp2_q.push_back(x2); name2_q.push_back({name, "_rs2"}); end
    tick();
    wb_valid = 1'b0; rs1_en = 1'b0; rs2_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Monitor: rsN_value is valid the edge after rsN_en was sampled high.
  initial begin
    logic v1, v2;
    forever begin
      @(posedge clk);
      v1 = rs1_en & ~rst;
      v2 = rs2_en & ~rst;
      #1;
      if (v1) begin
        if (exp1_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rs1_unexpected: got 0x%08h expected none", rs1_value);
        end else begin
          check(name1_q.pop_front(), rs1_value, exp1_q.pop_front());
        end
      end
      if (v2) begin
        if (exp2_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rs2_unexpected: got 0x%08h expected none", rs2_value);
        end else begin
          check(name2_q.pop_front(), rs2_value, exp2_q.pop_front());
        end
      end
    end
  end

  initial begin
    int waited;
    rst = 1'b1; wb_valid = 1'b0; wb_rd_addr = '0; wb_rd_value = '0;
    rs1_en = 1'b0; rs1_addr = '0; rs2_en = 1'b0; rs2_addr = '0;

    // Reset state
    tick();
    check("rst_wb_ready", {31'd0, wb_ready}, 32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_rs1_value", rs1_value, 32'd0);
    check("rst_rs2_value", rs2_value, 32'd0);

    // Clear sequence: 31 edges, handshake opens on edge 31
    rst = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      tick();
      check($sformatf("init_wb_ready_e%0d", i), {31'd0, wb_ready}, (i == 31) ? 32'd1 : 32'd0);
      check($sformatf("init_done_e%0d", i), {31'd0, init_done}, (i == 31) ? 32'd1 : 32'd0);
    end

    // All of x1..x31 read back as zero
    for (int i = 1; i <= 31; i++) begin
      cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'd0, 1'b1, 5'(32 - i), 32'd0, "clear");
    end

    // Write x5, then read it the next cycle through the pending entry
    cyc(1'b1, 5'd5, 32'h12345000, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, "wb_x5");
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h12345000, 1'b0, 5'd0, 32'd0, "fwd_pend_x5");
    idle(3);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h12345000, 1'b1, 5'd5, 32'h12345000, "arr_x5");

    // Write and read of x7 on the same edge
    cyc(1'b1, 5'd7, 32'hDEADB000, 1'b1, 5'd7, 32'hDEADB000, 1'b1, 5'd7, 32'hDEADB000, "same_edge_x7");
    idle(2);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEADB000, 1'b0, 5'd0, 32'd0, "arr_x7");

    // A write to x0 is discarded and leaves the other registers alone
    cyc(1'b1, 5'd0, 32'hFFFFF000, 1'b1, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, "wb_x0_same");
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'd0, 1'b1, 5'd5, 32'h12345000, "rd_x0");
    idle(2);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEADB000, "rd_x0_late");

    // Back-to-back writes to the same register: the later one wins
    cyc(1'b1, 5'd3, 32'h00001000, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, "wb_x3_a");
    cyc(1'b1, 5'd3, 32'h00002000, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, "wb_x3_b");
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h00002000, 1'b0, 5'd0, 32'd0, "b2b_same_x3");
    idle(2);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h00002000, 1'b0, 5'd0, 32'd0, "b2b_same_x3_arr");

    // Back-to-back writes to different registers: neither is lost
    cyc(1'b1, 5'd3, 32'h00001000, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, "wb_x3_c");
    cyc(1'b1, 5'd4, 32'h00002000, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, "wb_x4");
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h00001000, 1'b1, 5'd4, 32'h00002000, "b2b_diff");
    idle(2);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h00002000, 1'b1, 5'd3, 32'h00001000, "b2b_diff_arr");

    // Reset in RUN with x9 still pending.
    // The clear restarts, the write never lands, and x10 is held through INIT.
    cyc(1'b1, 5'd9, 32'hABCD0000, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, "wb_x9");
    rst = 1'b1;
    tick();
    check("rst2_wb_ready", {31'd0, wb_ready}, 32'd0);
    rst = 1'b0;
    wb_valid = 1'b1; wb_rd_addr = 5'd10; wb_rd_value = 32'h55AA0000;
    waited = 0;
    while (!wb_ready && waited < 64) begin
      tick();
      waited++;
    end
    check("rst2_init_edges", 32'(waited), 32'd31);
    if (!wb_ready) begin
      checks++; errors++;
      $display("FAIL rst2_ready_timeout: got wb_ready=0 expected 1");
    end
    // wb_ready is high now; the next edge accepts x10
    tick();
    wb_valid = 1'b0;
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'd0, 1'b1, 5'd10, 32'h55AA0000, "post_rst");
    idle(2);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h55AA0000, 1'b1, 5'd5, 32'd0, "post_rst_arr");

    idle(3);
    checks++;
    if (exp1_q.size() != 0 || exp2_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d entries left expected 0/0",
               exp1_q.size(), exp2_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
